// File: rtl/lzrw1_group_packer.sv
// LZRW1 group packer: gathers up to ITEMS_PER_GROUP literal/copy items,
// builds the control word, then streams control word and item bytes.
// The control word is emitted as exactly two bytes, so the byte layout
// assumes ITEMS_PER_GROUP = 16 and OFFSET_WIDTH = 12.
module lzrw1_group_packer #(
  parameter int ITEMS_PER_GROUP = 16,
  parameter int OFFSET_WIDTH    = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    item_valid,
  output logic                    item_ready,
  input  logic                    item_is_copy,
  input  logic [7:0]              item_literal,
  input  logic [OFFSET_WIDTH-1:0] item_offset,
  input  logic [4:0]              item_length,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_byte,
  output logic                    out_last,
  output logic                    done,
  output logic                    protocol_error
);

  localparam int BUF_DEPTH = 2 * ITEMS_PER_GROUP;
  localparam int IDX_W     = $clog2(BUF_DEPTH);
  localparam int CNT_W     = IDX_W + 1;
  localparam int ITEM_W    = $clog2(ITEMS_PER_GROUP) + 1;

  typedef enum logic [2:0] {
    FILL,
    CTRL_LO,
    CTRL_HI,
    ITEMS,
    FLUSH_DONE
  } state_t;

  state_t                     state, state_next;
  logic [ITEM_W-1:0]          item_count;
  logic [CNT_W-1:0]           byte_count;
  logic [ITEMS_PER_GROUP-1:0] control;
  logic [IDX_W-1:0]           emit_idx;
  logic                       final_group;
  logic [7:0]                 buffer [BUF_DEPTH];

  logic                       accept;
  logic [ITEM_W-1:0]          count_after;
  logic [4:0]                 length_m3;
  logic [7:0]                 copy_byte_a;
  logic [7:0]                 copy_byte_b;
  logic                       copy_illegal;
  logic                       last_byte;
  logic                       group_clear;

  assign accept       = (state == FILL) && item_valid;
  assign count_after  = item_count + ITEM_W'(accept);
  assign length_m3    = item_length - 5'd3;
  assign copy_byte_a  = {item_offset[OFFSET_WIDTH-1:8], length_m3[3:0]};
  assign copy_byte_b  = item_offset[7:0];
  assign copy_illegal = (item_length < 5'd3) || (item_length > 5'd18) ||
                        (item_offset == '0);
  assign last_byte    = ((CNT_W'(emit_idx) + CNT_W'(1)) == byte_count);
  // Group state is wiped once its last item byte leaves, or after a flush.
  assign group_clear  = ((state == ITEMS) && out_ready && last_byte) ||
                        (state == FLUSH_DONE);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) state <= FILL;
    else        state <= state_next;
  end

  // Next-state logic: close on a full group or flush, advance emits on handshake.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      FILL: begin
        if (accept && (count_after == ITEM_W'(ITEMS_PER_GROUP)))
          state_next = CTRL_LO;
        else if (flush)
          state_next = (count_after != '0) ? CTRL_LO : FLUSH_DONE;
      end
      CTRL_LO:    if (out_ready) state_next = CTRL_HI;
      CTRL_HI:    if (out_ready) state_next = ITEMS;
      ITEMS: begin
        if (out_ready && last_byte)
          state_next = final_group ? FLUSH_DONE : FILL;
      end
      FLUSH_DONE: state_next = FILL;
      default:    state_next = FILL;
    endcase
  end

  // Output decode: byte mux and handshake flags derived from the state.
  always_comb begin
    item_ready = 1'b0;
    out_valid  = 1'b0;
    out_byte   = 8'h00;
    out_last   = 1'b0;
    done       = 1'b0;
    case (state)
      FILL:       item_ready = 1'b1;
      CTRL_LO: begin
        out_valid = 1'b1;
        out_byte  = control[7:0];
      end
      CTRL_HI: begin
        out_valid = 1'b1;
        out_byte  = control[15:8];
      end
      ITEMS: begin
        out_valid = 1'b1;
        out_byte  = buffer[emit_idx];
        out_last  = final_group && last_byte;
      end
      FLUSH_DONE: done = 1'b1;
      default:    item_ready = 1'b0;
    endcase
  end

  // Group bookkeeping: item/byte counters, control bits, emit pointer, final flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      item_count  <= '0;
      byte_count  <= '0;
      control     <= '0;
      emit_idx    <= '0;
      final_group <= 1'b0;
    end else if (group_clear) begin
      item_count  <= '0;
      byte_count  <= '0;
      control     <= '0;
      emit_idx    <= '0;
      final_group <= 1'b0;
    end else begin
      if (accept) begin
        item_count <= count_after;
        byte_count <= byte_count + (item_is_copy ? CNT_W'(2) : CNT_W'(1));
        control[item_count[ITEM_W-2:0]] <= item_is_copy;
      end
      if ((state == FILL) && (state_next == CTRL_LO))
        final_group <= flush;
      if ((state == ITEMS) && out_ready)
        emit_idx <= emit_idx + IDX_W'(1);
    end
  end

  // Item byte storage; a copy writes two consecutive bytes.
  always_ff @(posedge clock) begin
    // NOTE: the buffer has no reset; byte_count bounds every read, so stale
    // contents are never emitted and the array can map to plain storage.
    if (accept) begin
      if (item_is_copy) begin
        buffer[byte_count[IDX_W-1:0]]              <= copy_byte_a;
        buffer[byte_count[IDX_W-1:0] + IDX_W'(1)]  <= copy_byte_b;
      end else begin
        buffer[byte_count[IDX_W-1:0]]              <= item_literal;
      end
    end
  end

  // Sticky flag for any illegal copy accepted since reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                             protocol_error <= 1'b0;
    else if (accept && item_is_copy && copy_illegal) protocol_error <= 1'b1;
  end

endmodule

// File: tb/tb_lzrw1_group_packer.sv
// Directed bench for lzrw1_group_packer with hand-computed byte streams.
module tb_lzrw1_group_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        item_valid;
  logic        item_ready;
  logic        item_is_copy;
  logic [7:0]  item_literal;
  logic [11:0] item_offset;
  logic [4:0]  item_length;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        done;
  logic        protocol_error;

  int n_checks = 0;
  int n_passed = 0;
  logic [7:0] exp_q [$];

  lzrw1_group_packer dut (
    .clock          (clock),
    .reset          (reset),
    .item_valid     (item_valid),
    .item_ready     (item_ready),
    .item_is_copy   (item_is_copy),
    .item_literal   (item_literal),
    .item_offset    (item_offset),
    .item_length    (item_length),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_byte       (out_byte),
    .out_last       (out_last),
    .done           (done),
    .protocol_error (protocol_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one item for a single cycle; the packer must be ready.
  task automatic send_item(input logic is_copy, input logic [7:0] lit,
                           input logic [11:0] off, input logic [4:0] len);
    check("item_ready_on_send", item_ready, 1);
    item_valid   = 1'b1;
    item_is_copy = is_copy;
    item_literal = lit;
    item_offset  = off;
    item_length  = len;
    step();
    item_valid   = 1'b0;
  endtask

  task automatic close_group();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // Consume exp_q; optionally toggles out_ready. busy_exp < 0 skips the
  // item_ready-low cycle count check.
  task automatic drain(input bit stall, input bit is_final, input int busy_exp);
    int k    = 0;
    int cyc  = 0;
    int busy = 0;
    int n    = exp_q.size();
    while (k < n && cyc < 400) begin
      out_ready = stall ? ((cyc % 2) == 0) : 1'b1;
      if (item_ready == 1'b0) busy++;
      if (out_valid) begin
        check(out_ready ? "out_byte" : "out_byte_held", out_byte, exp_q[k]);
        if (out_ready) begin
          check("out_last", out_last, (is_final && k == n - 1) ? 1 : 0);
          k++;
        end
      end
      step();
      cyc++;
    end
    out_ready = 1'b1;
    check("bytes_emitted", k, n);
    if (busy_exp >= 0) check("item_ready_low_cycles", busy, busy_exp);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_item_ready"}, item_ready, 1);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_out_byte"}, out_byte, 0);
    check({pfx, "_out_last"}, out_last, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_protocol_error"}, protocol_error, 0);
  endtask

  initial begin
    reset = 1'b0; item_valid = 1'b0; item_is_copy = 1'b0; item_literal = '0;
    item_offset = '0; item_length = '0; flush = 1'b0; out_ready = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(negedge clock); reset = 1'b1;
    step();

    // 16 literals: full group, control 0x0000.
    for (int i = 0; i < 16; i++) send_item(1'b0, 8'(8'h41 + i), '0, '0);
    check("full_out_valid_next_cycle", out_valid, 1);
    check("full_item_ready_low", item_ready, 0);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h41 + i));
    drain(1'b0, 1'b0, 18);
    check("full_back_to_fill", item_ready, 1);
    check("full_out_valid_idle", out_valid, 0);

    // 15 literals then a copy in slot 15: control 0x8000.
    for (int i = 0; i < 15; i++) send_item(1'b0, 8'h61, '0, '0);
    send_item(1'b1, 8'h00, 12'h123, 5'd5);
    exp_q.push_back(8'h00); exp_q.push_back(8'h80);
    for (int i = 0; i < 15; i++) exp_q.push_back(8'h61);
    exp_q.push_back(8'h12); exp_q.push_back(8'h23);
    drain(1'b0, 1'b0, 19);

    // Partial group closed by flush: control 0x0002.
    send_item(1'b0, 8'h01, '0, '0);
    send_item(1'b1, 8'h00, 12'h0FF, 5'd18);
    send_item(1'b0, 8'h02, '0, '0);
    close_group();
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(8'h02); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    exp_q.push_back(8'h0F); exp_q.push_back(8'hFF); exp_q.push_back(8'h02);
    drain(1'b0, 1'b1, -1);
    check("flush_done_pulse", done, 1);
    check("flush_done_no_valid", out_valid, 0);
    step();
    check("flush_done_one_cycle", done, 0);
    check("flush_item_ready_back", item_ready, 1);
    check("legal_copies_no_error", protocol_error, 0);

    // Flush with an empty group.
    close_group();
    check("empty_flush_done", done, 1);
    check("empty_flush_no_valid", out_valid, 0);
    check("empty_flush_not_ready", item_ready, 0);
    step();
    check("empty_flush_done_clear", done, 0);
    check("empty_flush_ready", item_ready, 1);

    // Full literal group with out_ready toggling.
    for (int i = 0; i < 16; i++) send_item(1'b0, 8'(8'h41 + i), '0, '0);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h41 + i));
    drain(1'b1, 1'b0, -1);
    check("stall_back_to_fill", item_ready, 1);

    // Illegal copy (length 2), then reset mid-emit.
    send_item(1'b1, 8'h00, 12'h005, 5'd2);
    check("illegal_copy_error", protocol_error, 1);
    close_group();
    out_ready = 1'b1;
    check("illegal_ctrl_lo", out_byte, 8'h01);
    step();
    check("illegal_ctrl_hi", out_byte, 8'h00);
    check("illegal_error_sticky", protocol_error, 1);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clock); reset = 1'b1;
    step();
    check_reset_outputs("postreset");

    // Buffer must start clean after the reset: one literal, flushed.
    send_item(1'b0, 8'h77, '0, '0);
    close_group();
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h77);
    drain(1'b0, 1'b1, -1);
    check("post_reset_done", done, 1);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
